sad_ctrl: RTL and testbench

SAD_CTRL -- requirements
Module: sad_ctrl

---
 rtl/sad_ctrl.sv | 81 ++++++++
 tb/tb_sad_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sad_ctrl.sv
// sad_ctrl: block sum-of-absolute-differences controller; define SAD_SATURATE_EN for a clamping accumulator with sticky ovf
module abs_diff #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d
);
  logic [W:0] s;
  assign s = {1'b0, a} - {1'b0, b};
  assign d = s[W] ? -s[W-1:0] : s[W-1:0];
endmodule

module sad_ctrl #(
  parameter int LEN_W = 5,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sad,
  output logic             ovf
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [LEN_W-1:0] rem;
  logic [3:0] d;
  logic acc, go;
  abs_diff #(.W(4)) u_abs (.a(A), .b(B), .d(d));
  assign in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign acc = in_valid & in_ready;
  assign go = (state == IDLE) & start;
  // block sequencing: length latched on start, counted down per accepted pair
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rem <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rem <= len;
          state <= (len == '0) ? DONE : RUN;
        end
        RUN: if (acc) begin
          rem <= rem - 1'b1;
          state <= (rem == LEN_W'(1)) ? DONE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SAD_SATURATE_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, sad} + (ACC_W+1)'(d);
  // accumulator clamps at full scale; ovf latches on the first carry-out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sad <= '0;
      ovf <= 1'b0;
    end else if (go) begin
      sad <= '0;
      ovf <= 1'b0;
    end else if (acc) begin
      sad <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
    end
`else
  assign ovf = 1'b0;
  // accumulator wraps modulo its width
  always_ff @(posedge clk or posedge rst)
    if (rst) sad <= '0;
    else if (go) sad <= '0;
    else if (acc) sad <= sad + ACC_W'(d);
`endif
endmodule

// File: tb/tb_sad_ctrl.sv
// tb_sad_ctrl: directed and randomized checks of sad_ctrl against an integer reference model
module tb_sad_ctrl;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [4:0] len = 0;
  logic [3:0] A = 0, B = 0;
  logic in_ready, busy, done, ovf;
  logic [7:0] sad;
  int n = 0, fails = 0;
  int pa [32], pb [32];
  int s;

  sad_ctrl dut (.clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .A(A), .B(B), .busy(busy), .done(done), .sad(sad), .ovf(ovf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  function automatic int exp_sad(input int t);
`ifdef SAD_SATURATE_EN
    return t > 255 ? 255 : t;
`else
    return t % 256;
`endif
  endfunction

  function automatic int exp_ovf(input int t);
`ifdef SAD_SATURATE_EN
    return t > 255 ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int absd(input int a, input int b);
    return a > b ? a - b : b - a;
  endfunction

  // gap < 0: random 0..3 idle cycles before each later pair; otherwise fixed count
  task automatic do_block(input int l, input int gap, input bit inject);
    int g;
    s = 0;
    @(negedge clk);
    start = 1; len = 5'(l);
    @(negedge clk);
    start = 0; len = 5'($urandom);
    for (int k = 0; k < l; k++) begin
      g = (k == 0) ? 0 : (gap < 0 ? $urandom_range(0, 3) : gap);
      repeat (g) begin
        in_valid = 0; A = 4'($urandom); B = 4'($urandom);
        chk("gap_rdy", in_ready, 1);
        chk("gap_busy", busy, 1);
        chk("gap_sad", sad, exp_sad(s));
        @(negedge clk);
      end
      chk("run_rdy", in_ready, 1);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      A = 4'(pa[k]); B = 4'(pb[k]); in_valid = 1;
      if (inject && k == 0) begin start = 1; len = 5'd7; end
      @(negedge clk);
      start = 0;
      s += absd(pa[k], pb[k]);
      chk("acc_sad", sad, exp_sad(s));
      chk("acc_ovf", ovf, exp_ovf(s));
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_rdy", in_ready, 0);
    chk("done_sad", sad, exp_sad(s));
    in_valid = 1; A = 4'd15; B = 4'd0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rdy", in_ready, 0);
    @(negedge clk);
    in_valid = 0;
    chk("idle_sad", sad, exp_sad(s));
    chk("idle_ovf", ovf, exp_ovf(s));
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_sad", sad, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst = 0;

    pa[0] = 5; pb[0] = 2; pa[1] = 2; pb[1] = 9; pa[2] = 7; pb[2] = 7;
    do_block(3, 0, 0);
    chk("len3_sad", sad, 10);

    do_block(0, 0, 0);
    chk("len0_sad", sad, 0);

    pa[0] = 0; pb[0] = 15; pa[1] = 15; pb[1] = 0;
    do_block(2, 3, 0);
    chk("gap_total", sad, 30);

    for (int k = 0; k < 31; k++) begin pa[k] = 15; pb[k] = 0; end
    do_block(31, 0, 0);
`ifdef SAD_SATURATE_EN
    chk("len31_sad", sad, 255);
    chk("len31_ovf", ovf, 1);
`else
    chk("len31_sad", sad, 209);
    chk("len31_ovf", ovf, 0);
`endif

    pa[0] = 1; pb[0] = 4; pa[1] = 9; pb[1] = 2;
    do_block(2, 0, 1);
    chk("inject_sad", sad, 10);

    @(negedge clk);
    start = 1; len = 5'd4;
    @(negedge clk);
    start = 0;
    in_valid = 1; A = 4'd6; B = 4'd1;
    @(negedge clk);
    A = 4'd2; B = 4'd10;
    @(negedge clk);
    chk("pre_rst_sad", sad, 13);
    rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_sad", sad, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    in_valid = 0; rst = 0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    pa[0] = 3; pb[0] = 8;
    do_block(1, 0, 0);
    chk("post_rst_sad", sad, 5);

    repeat (6) begin
      int l;
      l = $urandom_range(1, 31);
      for (int k = 0; k < l; k++) begin pa[k] = $urandom_range(0, 15); pb[k] = $urandom_range(0, 15); end
      do_block(l, -1, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
